// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    // Fetch sequencer states. IDLE gives one dead cycle after reset, FETCH
    // issues reads, DRAIN waits out a request made obsolete by a redirect,
    // and HALT parks the front end after a misaligned redirect.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_e;

    // Instruction word presented in the D-slot while it holds a bubble.
    localparam logic [31:0] BUBBLE_INSTR = 32'h0;

    // PC taken out of reset unless the instantiation overrides it.
    localparam logic [63:0] DEFAULT_RESET_PC = 64'h0;

    // A redirect target must be word aligned; low bits set means a bad target.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return (low_bits != 2'b00);
    endfunction

endpackage

// File: rtl/fetch_d_reg.sv
// F->D pipeline register. It holds its contents by default. It loads a new
// {instr, pc, pc+4} triple on load, and it clears to a bubble on flush.
// If both load and flush are asserted, flush wins.
module fetch_d_reg
    import fetch_pkg::*;
#(
    parameter int XLEN = 64,
    parameter int ILEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            flush,
    input  logic [ILEN-1:0] instr_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic [XLEN-1:0] pcplus4_in,
    output logic [ILEN-1:0] instr_out,
    output logic [XLEN-1:0] pc_out,
    output logic [XLEN-1:0] pcplus4_out,
    output logic            valid_out
);

    logic [ILEN-1:0] instr_d,   instr_q;
    logic [XLEN-1:0] pc_d,      pc_q;
    logic [XLEN-1:0] pcplus4_d, pcplus4_q;
    logic            valid_d,   valid_q;

    // Select the next D-slot contents: flush, load, or hold.
    always_comb begin
        instr_d   = instr_q;
        pc_d      = pc_q;
        pcplus4_d = pcplus4_q;
        valid_d   = valid_q;
        if (flush) begin
            instr_d   = ILEN'(BUBBLE_INSTR);
            pc_d      = '0;
            pcplus4_d = '0;
            valid_d   = 1'b0;
        end else if (load) begin
            instr_d   = instr_in;
            pc_d      = pc_in;
            pcplus4_d = pcplus4_in;
            valid_d   = 1'b1;
        end
    end

    // D-slot storage; reset leaves a bubble.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q   <= ILEN'(BUBBLE_INSTR);
            pc_q      <= '0;
            pcplus4_q <= '0;
            valid_q   <= 1'b0;
        end else begin
            instr_q   <= instr_d;
            pc_q      <= pc_d;
            pcplus4_q <= pcplus4_d;
            valid_q   <= valid_d;
        end
    end

    assign instr_out   = instr_q;
    assign pc_out      = pc_q;
    assign pcplus4_out = pcplus4_q;
    assign valid_out   = valid_q;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch controller. It owns the PC and runs req/ack reads against
// an IMEM with variable latency. It applies decode redirects and stalls, and
// it feeds the F->D register.
//
// IMEM handshake: imem_req is held high until imem_ack. While imem_req=1 and
// imem_ack=0, imem_addr does not change. An ack in the same cycle as the
// request completes that request. An ack is only consumed while the FSM is
// in FETCH or DRAIN, so an ack that arrives in any other state is ignored.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int          XLEN     = 64,
    parameter int          ILEN     = 32,
    parameter int          IMEM_AW  = 8,
    parameter logic [63:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               StallD,
    input  logic               PCSrcD,
    input  logic               JalD,
    input  logic [XLEN-1:0]    PCTargetD,
    output logic               imem_req,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic               imem_ack,
    input  logic [ILEN-1:0]    imem_rdata,
    output logic [ILEN-1:0]    InstrD,
    output logic [XLEN-1:0]    PCD,
    output logic [XLEN-1:0]    PCPlus4D,
    output logic               ValidD,
    output logic               misalign_err,
    output logic [31:0]        fetch_cnt,
    output logic [1:0]         state_dbg
);

    fetch_state_e    state_d, state_q;
    logic [XLEN-1:0] pc_d, pc_q;
    logic [XLEN-1:0] pend_tgt_d, pend_tgt_q;
    logic            misalign_d, misalign_q;
    logic [31:0]     fetch_cnt_d, fetch_cnt_q;

    logic [XLEN-1:0] pc_plus4;
    logic            redir;
    logic            tgt_bad;
    logic            req;
    logic            d_load;
    logic            d_flush;

    // A redirect from decode counts only when decode is not stalled.
    assign redir    = (PCSrcD | JalD) & ~StallD;
    assign tgt_bad  = is_misaligned(PCTargetD[1:0]);
    assign pc_plus4 = pc_q + XLEN'(4);

    // Next-state logic. The D-slot commands and the request are set here.
    // Every output starts from a hold/idle default.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        pend_tgt_d  = pend_tgt_q;
        misalign_d  = misalign_q;
        fetch_cnt_d = fetch_cnt_q;
        req         = 1'b0;
        d_load      = 1'b0;
        d_flush     = 1'b0;
        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                // A valid D-slot that cannot drain blocks new requests.
                req = ~(ValidD & StallD);
                if (redir && tgt_bad) begin
                    // A bad target wins over any ack in this cycle.
                    misalign_d = 1'b1;
                    d_flush    = 1'b1;
                    state_d    = HALT;
                end else if (redir && (imem_ack || !req)) begin
                    // Nothing is left in flight, so retarget immediately.
                    // Any ack data in this cycle belongs to the wrong path.
                    pc_d    = PCTargetD;
                    d_flush = 1'b1;
                end else if (redir) begin
                    // The old request must complete before the address can move.
                    pend_tgt_d = PCTargetD;
                    d_flush    = 1'b1;
                    state_d    = DRAIN;
                end else if (StallD) begin
                    // Hold the D-slot and the PC. An ack in this cycle is
                    // not consumed, so the same address is fetched again.
                    d_load  = 1'b0;
                    d_flush = 1'b0;
                end else if (imem_ack) begin
                    d_load      = 1'b1;
                    pc_d        = pc_plus4;
                    fetch_cnt_d = fetch_cnt_q + 32'd1;
                end else begin
                    d_flush = 1'b1;
                end
            end
            DRAIN: begin
                // Keep the old address until its ack, then discard the data.
                req = 1'b1;
                if (imem_ack) begin
                    pc_d    = pend_tgt_q;
                    state_d = FETCH;
                end
            end
            HALT: begin
                d_flush = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Sequencer state, PC, pending target, sticky error and delivery count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            pc_q        <= XLEN'(RESET_PC);
            pend_tgt_q  <= '0;
            misalign_q  <= 1'b0;
            fetch_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            pend_tgt_q  <= pend_tgt_d;
            misalign_q  <= misalign_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    fetch_d_reg #(
        .XLEN (XLEN),
        .ILEN (ILEN)
    ) u_d_reg (
        .clk         (clk),
        .rst         (rst),
        .load        (d_load),
        .flush       (d_flush),
        .instr_in    (imem_rdata),
        .pc_in       (pc_q),
        .pcplus4_in  (pc_plus4),
        .instr_out   (InstrD),
        .pc_out      (PCD),
        .pcplus4_out (PCPlus4D),
        .valid_out   (ValidD)
    );

    assign imem_req     = req;
    assign imem_addr    = pc_q[IMEM_AW+1:2];
    assign misalign_err = misalign_q;
    assign fetch_cnt    = fetch_cnt_q;
    assign state_dbg    = state_q;

endmodule
